// File: rtl/temp_fifo.sv
// temp_fifo: DEPTH-entry first-word-fall-through buffer for temporary operands.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   reg_wr, reg_rd      push temp_in / pop head this cycle
//   flush               synchronous clear of contents and error flags
//   temp_in             data to push
//   temp_out            head entry, 0 when empty
//   full, empty, count  occupancy status
//   ovf, udf            sticky overflow / underflow flags
module temp_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic             flush,
  input  logic [WIDTH-1:0] temp_in,
  output logic [WIDTH-1:0] temp_out,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             udf
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             push_ok;
  logic             pop_ok;

  // Status decode from the registered count
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A full buffer still accepts a push when the head is popped in the same cycle
  assign push_ok = reg_wr & (~full | reg_rd);
  assign pop_ok  = reg_rd & ~empty;

  // First-word fall-through head, driven only from registered state
  assign temp_out = empty ? '0 : mem[rp];

  // Storage array; contents are not reset
  always_ff @(posedge clk) begin
    if (!flush && push_ok) begin
      mem[wp] <= temp_in;
    end
  end

  // Pointers, occupancy and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (push_ok) begin
        wp <= wp + AW'(1);
      end
      if (pop_ok) begin
        rp <= rp + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + (AW+1)'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - (AW+1)'(1);
      end
      if (reg_wr && full && !reg_rd) begin
        ovf <= 1'b1;
      end
      if (reg_rd && empty) begin
        udf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_temp_fifo.sv
module tb_temp_fifo;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic             clk;
  logic             rst_n;
  logic             reg_wr;
  logic             reg_rd;
  logic             flush;
  logic [WIDTH-1:0] temp_in;
  logic [WIDTH-1:0] temp_out;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             ovf;
  logic             udf;

  int checks;
  int errors;

  // Reference model: queue of live entries plus sticky flags
  logic [WIDTH-1:0] q[$];
  logic             m_ovf;
  logic             m_udf;

  temp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_rd(reg_rd), .flush(flush),
    .temp_in(temp_in), .temp_out(temp_out), .full(full), .empty(empty),
    .count(count), .ovf(ovf), .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] m_head();
    return (q.size() > 0) ? q[0] : '0;
  endfunction

  function automatic logic [AW:0] m_count();
    return (AW+1)'(q.size());
  endfunction

  // Apply one cycle of inputs and advance the model by the buffer's rules
  task automatic step(input logic wr, input logic rd, input logic fl, input logic [WIDTH-1:0] din);
    int n;
    reg_wr = wr; reg_rd = rd; flush = fl; temp_in = din;
    @(posedge clk);
    n = q.size();
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (rd && n == 0) m_udf = 1'b1;
      if (wr && n == DEPTH && !rd) m_ovf = 1'b1;
      if (rd && n > 0) void'(q.pop_front());
      if (wr && (n < DEPTH || rd)) q.push_back(din);
    end
    #1;
    reg_wr = 1'b0; reg_rd = 1'b0; flush = 1'b0; temp_in = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_init: count=%0d empty=%b full=%b exp 0/1/0", count, empty, full); end
    checks++; if (temp_out !== 16'h0000 || ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL reset_init_out: temp_out=%h ovf=%b udf=%b exp 0000/0/0", temp_out, ovf, udf); end
    rst_n = 1'b1;
    step(1, 0, 0, 16'h1234);
    step(1, 0, 0, 16'h5678);
    step(1, 0, 0, 16'h9ABC);
    checks++; if (count !== 3'd3 || temp_out !== 16'h1234) begin errors++; $display("FAIL pre_reset: count=%0d temp_out=%h exp 3/1234", count, temp_out); end
    rst_n = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    checks++; if (count !== 3'd0 || empty !== 1'b1 || temp_out !== 16'h0000) begin errors++; $display("FAIL async_reset: count=%0d empty=%b temp_out=%h exp 0/1/0000", count, empty, temp_out); end
    checks++; if (ovf !== 1'b0 || udf !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL async_reset_flags: ovf=%b udf=%b full=%b exp 0/0/0", ovf, udf, full); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] exp_seq [4];
    exp_seq[0] = 16'hCC33; exp_seq[1] = 16'h1111; exp_seq[2] = 16'h2222; exp_seq[3] = 16'h0000;
    step(1, 0, 0, 16'h33CC);
    checks++; if (temp_out !== 16'h33CC || count !== 3'd1) begin errors++; $display("FAIL fwft: temp_out=%h count=%0d exp 33CC/1", temp_out, count); end
    step(1, 0, 0, 16'hCC33);
    step(1, 0, 0, 16'h1111);
    step(1, 0, 0, 16'h2222);
    checks++; if (full !== 1'b1 || count !== 3'd4 || temp_out !== 16'h33CC) begin errors++; $display("FAIL filled: full=%b count=%0d temp_out=%h exp 1/4/33CC", full, count, temp_out); end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, '0);
      checks++; if (temp_out !== exp_seq[i] || count !== 3'(3 - i)) begin errors++; $display("FAIL drain[%0d]: temp_out=%h count=%0d exp %h/%0d", i, temp_out, count, exp_seq[i], 3 - i); end
    end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL drained: empty=%b full=%b exp 1/0", empty, full); end
  endtask

  task automatic test_overflow();
    step(1, 0, 0, 16'h33CC);
    step(1, 0, 0, 16'hCC33);
    step(1, 0, 0, 16'h1111);
    step(1, 0, 0, 16'h2222);
    step(1, 0, 0, 16'hDEAD);
    checks++; if (ovf !== 1'b1 || count !== 3'd4 || temp_out !== 16'h33CC) begin errors++; $display("FAIL ovf_drop: ovf=%b count=%0d temp_out=%h exp 1/4/33CC", ovf, count, temp_out); end
    step(1, 1, 0, 16'hBEEF);
    checks++; if (count !== 3'd4 || temp_out !== 16'hCC33 || full !== 1'b1) begin errors++; $display("FAIL full_rdwr: count=%0d temp_out=%h full=%b exp 4/CC33/1", count, temp_out, full); end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, '0);
      checks++; if (temp_out !== m_head()) begin errors++; $display("FAIL ovf_drain[%0d]: temp_out=%h exp %h", i, temp_out, m_head()); end
    end
    checks++; if (ovf !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL ovf_sticky: ovf=%b empty=%b exp 1/1", ovf, empty); end
  endtask

  task automatic test_underflow();
    step(0, 0, 1, '0);
    checks++; if (ovf !== 1'b0 || udf !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL flush_clear: ovf=%b udf=%b count=%0d exp 0/0/0", ovf, udf, count); end
    step(0, 1, 0, '0);
    checks++; if (udf !== 1'b1 || count !== 3'd0 || temp_out !== 16'h0000) begin errors++; $display("FAIL udf: udf=%b count=%0d temp_out=%h exp 1/0/0000", udf, count, temp_out); end
    step(1, 1, 0, 16'h0A0A);
    checks++; if (count !== 3'd1 || temp_out !== 16'h0A0A || udf !== 1'b1) begin errors++; $display("FAIL empty_rdwr: count=%0d temp_out=%h udf=%b exp 1/0A0A/1", count, temp_out, udf); end
    step(0, 1, 0, '0);
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] sent[$];
    step(0, 0, 1, '0);
    step(1, 0, 0, 16'h0100); sent.push_back(16'h0100);
    step(1, 0, 0, 16'h0101); sent.push_back(16'h0101);
    for (int i = 0; i < 10; i++) begin
      logic [WIDTH-1:0] v;
      v = 16'h0102 + 16'(i);
      step(1, 1, 0, v);
      sent.push_back(v);
      checks++; if (temp_out !== sent[i + 1] || count !== 3'd2) begin errors++; $display("FAIL wrap[%0d]: temp_out=%h count=%0d exp %h/2", i, temp_out, count, sent[i + 1]); end
    end
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    checks++; if (empty !== 1'b1 || udf !== 1'b0) begin errors++; $display("FAIL wrap_end: empty=%b udf=%b exp 1/0", empty, udf); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 16'hF000 + 16'(i));
    step(0, 1, 0, '0);
    checks++; if (count !== 3'd3 || ovf !== 1'b1) begin errors++; $display("FAIL flush_setup: count=%0d ovf=%b exp 3/1", count, ovf); end
    step(1, 0, 1, 16'h7777);
    checks++; if (count !== 3'd0 || empty !== 1'b1 || ovf !== 1'b0 || temp_out !== 16'h0000) begin errors++; $display("FAIL flush_wr: count=%0d empty=%b ovf=%b temp_out=%h exp 0/1/0/0000", count, empty, ovf, temp_out); end
    step(0, 0, 0, '0);
    checks++; if (count !== 3'd0 || temp_out !== 16'h0000) begin errors++; $display("FAIL flush_hold: count=%0d temp_out=%h exp 0/0000", count, temp_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic wr, rd, fl;
      wr = 1'($urandom_range(0, 99) < 55);
      rd = 1'($urandom_range(0, 99) < 45);
      fl = 1'($urandom_range(0, 99) < 3);
      step(wr, rd, fl, 16'($urandom));
      checks++; if (temp_out !== m_head()) begin errors++; $display("FAIL rnd_out[%0d]: temp_out=%h exp %h", i, temp_out, m_head()); end
      checks++; if (count !== m_count() || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_occ[%0d]: count=%0d full=%b empty=%b exp count %0d", i, count, full, empty, q.size()); end
      checks++; if (ovf !== m_ovf || udf !== m_udf) begin errors++; $display("FAIL rnd_flags[%0d]: ovf=%b udf=%b exp %b/%b", i, ovf, udf, m_ovf, m_udf); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    m_ovf = 1'b0; m_udf = 1'b0;
    reg_wr = 1'b0; reg_rd = 1'b0; flush = 1'b0; temp_in = '0; rst_n = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
